// File: rtl/srb_entry_buf.sv
// Sparse read buffer entry storage: allocation, out-of-order fill,
// oldest-first drain through a registered valid/ready output.
module srb_entry_buf #(
    parameter  int SRB_DEPTH = 8,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 64,
    localparam int PW        = $clog2(SRB_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    input  logic [ADDR_W-1:0]    alloc_addr,
    output logic                 alloc_ready,
    output logic [PW-1:0]        alloc_ptr,
    input  logic [PW-1:0]        w_ptr,
    output logic                 w_req_valid,
    input  logic                 fill_valid,
    input  logic [PW-1:0]        fill_ptr,
    input  logic [DATA_W-1:0]    fill_data,
    input  logic [PW-1:0]        bottom_ptr,
    output logic [SRB_DEPTH-1:0] entry_valid,
    output logic                 r_req_valid,
    output logic [PW-1:0]        r_req_ptr,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [PW-1:0]        rd_ptr,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 fill_err
);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_PEND = 2'd1,
        ST_DONE = 2'd2
    } ent_st_t;

    ent_st_t           st_q   [SRB_DEPTH];
    ent_st_t           st_d   [SRB_DEPTH];
    logic [ADDR_W-1:0] addr_q [SRB_DEPTH];
    logic [DATA_W-1:0] data_q [SRB_DEPTH];

    logic          fill_hit;
    logic          cand_found;
    logic [PW-1:0] cand_ptr;
    logic [PW-1:0] scan_idx;
    logic          load;

    assign alloc_ptr   = w_ptr;
    assign alloc_ready = (st_q[w_ptr] == ST_FREE);
    assign w_req_valid = alloc_valid & alloc_ready;
    assign fill_hit    = fill_valid & (st_q[fill_ptr] == ST_PEND);

    // Circular scan from the oldest slot; first DONE hit wins.
    always_comb begin
        cand_found = 1'b0;
        cand_ptr   = '0;
        scan_idx   = '0;
        for (int k = 0; k < SRB_DEPTH; k++) begin
            scan_idx = bottom_ptr + PW'(unsigned'(k));
            if (!cand_found && st_q[scan_idx] == ST_DONE) begin
                cand_found = 1'b1;
                cand_ptr   = scan_idx;
            end
        end
    end

    assign load        = cand_found & (~rd_valid | rd_ready);
    assign r_req_valid = load;
    assign r_req_ptr   = cand_ptr;

    always_comb begin
        for (int i = 0; i < SRB_DEPTH; i++) begin
            entry_valid[i] = (st_q[i] != ST_FREE) &&
                             !(load && cand_ptr == PW'(unsigned'(i)));
        end
    end

    // Alloc, fill and load always hit distinct entries (FREE/PEND/DONE).
    always_comb begin
        for (int i = 0; i < SRB_DEPTH; i++) begin
            st_d[i] = st_q[i];
        end
        if (w_req_valid) st_d[w_ptr]    = ST_PEND;
        if (fill_hit)    st_d[fill_ptr] = ST_DONE;
        if (load)        st_d[cand_ptr] = ST_FREE;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SRB_DEPTH; i++) begin
            st_q[i] <= rst ? ST_FREE : st_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_req_valid) addr_q[w_ptr]    <= alloc_addr;
        if (!rst && fill_hit)    data_q[fill_ptr] <= fill_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_ptr   <= '0;
            rd_addr  <= '0;
            rd_data  <= '0;
        end else if (load) begin
            rd_valid <= 1'b1;
            rd_ptr   <= cand_ptr;
            rd_addr  <= addr_q[cand_ptr];
            rd_data  <= data_q[cand_ptr];
        end else if (rd_ready) begin
            rd_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_err <= 1'b0;
        end else if (fill_valid && !fill_hit) begin
            fill_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_srb_entry_buf.sv
// Bench for srb_entry_buf: directed scenarios plus random traffic
// compared every cycle against a per-entry occupancy model.
module tb_srb_entry_buf;

    localparam int D  = 8;
    localparam int AW = 32;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic [AW-1:0] alloc_addr;
    logic          alloc_ready;
    logic [2:0]    alloc_ptr;
    logic [2:0]    w_ptr;
    logic          w_req_valid;
    logic          fill_valid;
    logic [2:0]    fill_ptr;
    logic [DW-1:0] fill_data;
    logic [2:0]    bottom_ptr;
    logic [D-1:0]  entry_valid;
    logic          r_req_valid;
    logic [2:0]    r_req_ptr;
    logic          rd_valid;
    logic          rd_ready;
    logic [2:0]    rd_ptr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          fill_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    logic [2:0] drain_q[$];

    // Model: each entry is free, waiting for data, or holding data.
    bit            m_pend [D];
    bit            m_done [D];
    logic [AW-1:0] m_addr [D];
    logic [DW-1:0] m_data [D];
    bit            m_rv;
    logic [2:0]    m_rptr;
    logic [AW-1:0] m_raddr;
    logic [DW-1:0] m_rdata;
    bit            m_err;

    srb_entry_buf #(.SRB_DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
        .w_ptr(w_ptr), .w_req_valid(w_req_valid),
        .fill_valid(fill_valid), .fill_ptr(fill_ptr),
        .fill_data(fill_data), .bottom_ptr(bottom_ptr),
        .entry_valid(entry_valid), .r_req_valid(r_req_valid),
        .r_req_ptr(r_req_ptr), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_ptr(rd_ptr), .rd_addr(rd_addr),
        .rd_data(rd_data), .fill_err(fill_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void meval(output bit fnd, output int cnd,
                                  output bit ld);
        fnd = 1'b0;
        cnd = 0;
        for (int k = 0; k < D; k++) begin
            int j = (int'(bottom_ptr) + k) % D;
            if (!fnd && m_done[j]) begin
                fnd = 1'b1;
                cnd = j;
            end
        end
        ld = fnd && (!m_rv || rd_ready);
    endfunction

    always @(posedge clk) begin : model_upd
        bit f;
        int c;
        bit l;
        bit a_ok;
        bit f_ok;
        meval(f, c, l);
        a_ok = alloc_valid && !m_pend[w_ptr] && !m_done[w_ptr];
        f_ok = fill_valid && m_pend[fill_ptr];
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                m_pend[i] <= 1'b0;
                m_done[i] <= 1'b0;
            end
            m_rv    <= 1'b0;
            m_rptr  <= '0;
            m_raddr <= '0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else begin
            if (a_ok) begin
                m_pend[w_ptr] <= 1'b1;
                m_addr[w_ptr] <= alloc_addr;
            end
            if (f_ok) begin
                m_pend[fill_ptr] <= 1'b0;
                m_done[fill_ptr] <= 1'b1;
                m_data[fill_ptr] <= fill_data;
            end else if (fill_valid) begin
                m_err <= 1'b1;
            end
            if (l) begin
                m_done[c] <= 1'b0;
                m_rv      <= 1'b1;
                m_rptr    <= 3'(c);
                m_raddr   <= m_addr[c];
                m_rdata   <= m_data[c];
            end else if (m_rv && rd_ready) begin
                m_rv <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin : compare
        bit f;
        int c;
        bit l;
        logic [D-1:0] ev;
        bit free_w;
        if (chk_en) begin
            meval(f, c, l);
            for (int i = 0; i < D; i++) begin
                ev[i] = (m_pend[i] || m_done[i]) && !(l && c == i);
            end
            free_w = !m_pend[w_ptr] && !m_done[w_ptr];
            chk("alloc_ready", alloc_ready, free_w);
            chk("alloc_ptr", alloc_ptr, w_ptr);
            chk("w_req_valid", w_req_valid, alloc_valid && free_w);
            chk("r_req_valid", r_req_valid, l);
            if (l) chk("r_req_ptr", r_req_ptr, c);
            chk("entry_valid", entry_valid, ev);
            chk("rd_valid", rd_valid, m_rv);
            chk("rd_ptr", rd_ptr, m_rptr);
            chk("rd_addr", rd_addr, m_raddr);
            chk("rd_data", rd_data, m_rdata);
            chk("fill_err", fill_err, m_err);
            if (r_req_valid) drain_q.push_back(r_req_ptr);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 1'b0;
        fill_valid  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic alloc_one(input logic [2:0] p, input logic [AW-1:0] a);
        alloc_valid = 1'b1;
        w_ptr       = p;
        alloc_addr  = a;
        cyc();
        alloc_valid = 1'b0;
    endtask

    task automatic fill_one(input logic [2:0] p, input logic [DW-1:0] d);
        fill_valid = 1'b1;
        fill_ptr   = p;
        fill_data  = d;
        cyc();
        fill_valid = 1'b0;
    endtask

    task automatic chk_drain(string name, input logic [2:0] exp[$]);
        chk({name, "_len"}, drain_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < drain_q.size(); i++) begin
            chk(name, drain_q[i], exp[i]);
        end
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0;
        alloc_addr = '0;
        w_ptr = '0;
        fill_valid = 1'b0;
        fill_ptr = '0;
        fill_data = '0;
        bottom_ptr = '0;
        rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_entry_valid", entry_valid, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_fill_err", fill_err, 0);

        // basic
        cyc();
        alloc_one(3'd0, 32'h100);
        fill_one(3'd0, 64'hAA);
        @(negedge clk);
        chk("basic_rreq", r_req_valid, 1);
        chk("basic_rreq_ptr", r_req_ptr, 0);
        cyc();
        @(negedge clk);
        chk("basic_rd_valid", rd_valid, 1);
        chk("basic_rd_addr", rd_addr, 32'h100);
        chk("basic_rd_data", rd_data, 64'hAA);
        cyc();

        // out-of-order fill
        do_reset();
        for (int i = 0; i < 3; i++) alloc_one(3'(i), 32'h200 + i);
        drain_q.delete();
        fill_one(3'd2, 64'h22);
        fill_one(3'd1, 64'h11);
        fill_one(3'd0, 64'h00);
        repeat (3) cyc();
        chk_drain("ooo_order", '{3'd2, 3'd1, 3'd0});
        @(negedge clk);
        chk("ooo_empty", entry_valid, 0);
        cyc();

        // oldest-first with wrap
        do_reset();
        rd_ready = 1'b0;
        bottom_ptr = 3'd5;
        for (int i = 5; i < 9; i++) alloc_one(3'(i), 32'h300 + i);
        drain_q.delete();
        fill_one(3'd5, 64'h55);
        fill_one(3'd0, 64'h60);
        fill_one(3'd7, 64'h77);
        fill_one(3'd6, 64'h66);
        bottom_ptr = 3'd6;
        rd_ready = 1'b1;
        @(negedge clk);
        chk("old_first", r_req_ptr, 6);
        cyc();
        @(negedge clk);
        chk("old_second", r_req_ptr, 7);
        cyc();
        @(negedge clk);
        chk("old_wrap", r_req_ptr, 0);
        cyc();
        cyc();
        chk_drain("old_order", '{3'd5, 3'd6, 3'd7, 3'd0});

        // full
        do_reset();
        bottom_ptr = 3'd0;
        for (int i = 0; i < 8; i++) alloc_one(3'(i), 32'h400 + i);
        alloc_valid = 1'b1;
        w_ptr = 3'd0;
        @(negedge clk);
        chk("full_ready", alloc_ready, 0);
        chk("full_wreq", w_req_valid, 0);
        fill_valid = 1'b1;
        fill_ptr = 3'd0;
        fill_data = 64'hF0;
        cyc();
        fill_valid = 1'b0;
        @(negedge clk);
        chk("full_load", r_req_valid, 1);
        chk("full_ready_load", alloc_ready, 0);
        cyc();
        @(negedge clk);
        chk("full_ready_after", alloc_ready, 1);
        cyc();
        alloc_valid = 1'b0;

        // backpressure
        do_reset();
        rd_ready = 1'b0;
        alloc_one(3'd0, 32'h500);
        alloc_one(3'd1, 32'h501);
        drain_q.delete();
        fill_one(3'd0, 64'hB0);
        fill_one(3'd1, 64'hB1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", rd_valid, 1);
            chk("bp_hold_ptr", rd_ptr, 0);
            chk("bp_hold_data", rd_data, 64'hB0);
            cyc();
        end
        chk("bp_one_pulse", drain_q.size(), 1);
        rd_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", r_req_ptr, 1);
        cyc();
        @(negedge clk);
        chk("bp_second", rd_ptr, 1);
        chk("bp_second_data", rd_data, 64'hB1);
        cyc();

        // error and mid-operation reset
        do_reset();
        fill_one(3'd3, 64'hEE);
        @(negedge clk);
        chk("err_flag", fill_err, 1);
        chk("err_nochange", entry_valid, 0);
        for (int i = 0; i < 4; i++) alloc_one(3'(i), 32'h600 + i);
        @(negedge clk);
        chk("err_pend4", entry_valid, 8'h0F);
        do_reset();
        @(negedge clk);
        chk("rst_mid_ev", entry_valid, 0);
        chk("rst_mid_err", fill_err, 0);
        chk("rst_mid_rv", rd_valid, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            alloc_valid = !rst && ($urandom_range(0, 1) == 1);
            w_ptr = 3'($urandom);
            alloc_addr = $urandom;
            fill_valid = !rst && ($urandom_range(0, 2) != 0);
            fill_ptr = 3'($urandom);
            for (int t = 0; t < 4 && !m_pend[fill_ptr]; t++) begin
                fill_ptr = 3'($urandom);
            end
            fill_data = {$urandom, $urandom};
            bottom_ptr = 3'($urandom);
            rd_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/srb_entry_buf.md
# srb_entry_buf

Entry storage and sequencing for the sparse read buffer. Allocates entries at the write pointer supplied by the pointer generator and accepts out-of-order fill responses tagged by entry index. Drains filled entries oldest-first, scanning from the bottom pointer, through a registered valid/ready output. Reports each freed entry back to the pointer generator (`w_req_valid`, `r_req_valid`/`r_req_ptr`) and exports the occupancy mask it consumes (`entry_valid`).

## Interface

Parameters:
- `SRB_DEPTH`, 8: number of entries; power of two, ≥2. `PW` = `$clog2(SRB_DEPTH)`.
- `ADDR_W`, 32: request address width.
- `DATA_W`, 64: fill data width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `alloc_valid`  in  1  allocation request.
- `alloc_addr`  in  ADDR_W  address stored with the entry.
- `alloc_ready`  out  1  slot at `w_ptr` is FREE.
- `alloc_ptr`  out  PW  index granted; equals `w_ptr`.
- `w_ptr`  in  PW  write pointer from the pointer generator.
- `w_req_valid`  out  1  allocation fire (`alloc_valid & alloc_ready`); advances `w_ptr`.
- `fill_valid`  in  1  fill response.
- `fill_ptr`  in  PW  entry being filled.
- `fill_data`  in  DATA_W  fill payload.
- `bottom_ptr`  in  PW  oldest-occupied index from the pointer generator.
- `entry_valid`  out  SRB_DEPTH  occupancy mask (post-free view; see Operation).
- `r_req_valid`  out  1  an entry is freed this cycle.
- `r_req_ptr`  out  PW  index of the freed entry.
- `rd_valid`  out  1  output register holds data.
- `rd_ready`  in  1  consumer accepts.
- `rd_ptr`  out  PW  entry index of the output data.
- `rd_addr`  out  ADDR_W  stored address.
- `rd_data`  out  DATA_W  fill data.
- `fill_err`  out  1  sticky protocol-error flag.

## Operation

- **Per-entry state machine**, 2-bit state: FREE → PEND (alloc fire) → DONE (fill) → FREE (selected into the output register).
- **Allocation:**
  - `alloc_ready` = (state[`w_ptr`] == FREE), computed from registered state only. There is no same-cycle bypass of a slot being freed.
  - On fire: entry `w_ptr` ← PEND and `addr[w_ptr]` ← `alloc_addr`.
- **Fill:**
  - If `fill_valid` and state[`fill_ptr`] == PEND: `data` ← `fill_data`, state ← DONE.
  - A fill to a FREE or DONE entry is ignored (no state or data change) and sets `fill_err`, which stays set until `rst`.
- **Selection:**
  - Candidate = first DONE entry scanning circularly from `bottom_ptr` (offsets 0..SRB_DEPTH-1, wrap modulo SRB_DEPTH).
  - Load condition: `load` = candidate exists & (~`rd_valid` | `rd_ready`).
- **On load:**
  - Output register ← {ptr, addr, data} of the candidate; `rd_valid` ← 1.
  - Candidate state ← FREE.
  - `r_req_valid` = 1 and `r_req_ptr` = candidate, combinationally in the same cycle.
- **Output register:** on `rd_valid & rd_ready` with no load, `rd_valid` ← 0. Outputs hold stable while `rd_valid & ~rd_ready`.
- **`entry_valid`:**
  - Bit i = (state[i] != FREE), with bit `r_req_ptr` forced to 0 while `r_req_valid`.
  - The downstream pointer logic therefore sees post-free occupancy.
- **Simultaneous events:**
  - Alloc, fill and load in one cycle are independent and all take effect when they target distinct entries.
  - A fill cannot collide with a load on the same entry, since a load requires DONE.
  - Alloc to the slot being loaded is blocked by `alloc_ready`.
- **Full / empty:**
  - Full: state[`w_ptr`] != FREE, giving `alloc_ready` = 0.
  - Empty: no DONE entries, so no load and `r_req_valid` = 0.

## Timing

- **Reset values:**
  - All entries FREE.
  - `rd_valid` = 0, `fill_err` = 0, `alloc_ready` = 1.
  - `r_req_valid` = 0, `w_req_valid` = 0, `entry_valid` = 0.
  - `rd_ptr`/`rd_addr`/`rd_data` = 0.
- **`rst` mid-operation:** all PEND/DONE entries and the output register are discarded on the next edge. Inputs in the reset cycle are ignored.
- **Latency:**
  - Alloc fire at cycle N → PEND at N+1.
  - Fill at cycle M → DONE at M+1 → earliest load at M+1 (`r_req_valid` high in M+1) → `rd_valid` at M+2.
- **Throughput:** one load per cycle with `rd_ready` held high.
- **Combinational outputs:** `alloc_ready`, `alloc_ptr`, `w_req_valid`, `r_req_valid`/`r_req_ptr` and `entry_valid` are combinational from registered state and current inputs. There is no combinational path from `rd_ready` to `rd_valid`.

## Test plan

- **Basic:** reset; alloc addr 0x100 at `w_ptr`=0; fill ptr 0 with 0xAA → `r_req_valid`/`r_req_ptr`=0 one cycle after the fill; `rd_valid`=1, `rd_addr`=0x100, `rd_data`=0xAA the cycle after.
- **Out-of-order fill:** alloc entries 0,1,2; fill 2, then 1, then 0 on consecutive cycles with `bottom_ptr`=0 → drain order 2,1,0; final `entry_valid`=0.
- **Oldest-first selection:** entries 6,7,0 DONE, `bottom_ptr`=6, `rd_ready`=1 → loads 6,7,0 in consecutive cycles (wrap-around).
- **Full:** allocate 8 with no fills → `alloc_ready`=0 at `w_ptr`=0; fill 0 → ready stays 0 in the load cycle and rises the cycle after the load frees slot 0.
- **Backpressure:** `rd_ready`=0 with 2 DONE entries → `rd_valid` held, outputs stable, one `r_req_valid` pulse only; raise `rd_ready` → second entry appears on the next cycle.
- **Errors / reset:** fill ptr 3 while FREE → `fill_err`=1, no state change; assert `rst` with 4 PEND entries → next cycle `entry_valid`=0, `fill_err`=0, `rd_valid`=0.
